// File: rtl/rst_sequencer.sv
// rst_sequencer: filtered, stretched and staggered reset controller
// for the ULA CPLD, with a sticky reset-cause register.
module rst_sequencer #(
  parameter int NCH     = 3,
  parameter int NSRC    = 2,
  parameter int FILT_W  = 3,
  parameter int STRETCH = 8,
  parameter int STAGGER = 4,
  parameter int BLANK   = 16
) (
  input  logic            clk28,
  input  logic            rst,
  input  logic            por_n,
  input  logic [NSRC-1:0] src_req,
  input  logic            cpu_rst_pin_n,
  output logic            cpu_rst_oe,
  output logic [NCH-1:0]  dom_rst_n,
  output logic [NSRC+1:0] cause,
  input  logic            cause_clr,
  output logic            busy
);
  localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam int GW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(STRETCH - 1);
  localparam logic [GW-1:0] G_MAX = GW'(STAGGER - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLANK - 1);

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    RUN
  } state_t;

  state_t state_q, state_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [GW-1:0] gc_q, gc_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [NCH-1:0] dom_q, dom_d;
  logic oe_q, oe_d;
  logic busy_q;
  logic [NSRC+1:0] cause_q;

  logic [1:0] por_sync, pin_sync;
  logic [FILT_W-1:0] por_cnt, pin_cnt;
  logic por_evt, ext_evt, pin_en, trig;

  assign por_evt = &por_cnt;
  assign ext_evt = &pin_cnt;
  // The pin is only trusted once our own drive has had time to recover.
  assign pin_en = (state_q == RUN) && (bc_q == '0);
  assign trig = por_evt | ext_evt | (|src_req);

  always_ff @(posedge clk28) begin
    if (rst) begin
      por_sync <= 2'b11;
      pin_sync <= 2'b11;
      por_cnt  <= '0;
      pin_cnt  <= '0;
      cause_q  <= (NSRC+2)'(1);
    end else begin
      por_sync <= {por_sync[0], por_n};
      pin_sync <= {pin_sync[0], cpu_rst_pin_n};
      if (por_sync[1])
        por_cnt <= '0;
      else if (!por_evt)
        por_cnt <= por_cnt + FILT_W'(1);
      if (!pin_en || pin_sync[1])
        pin_cnt <= '0;
      else if (!ext_evt)
        pin_cnt <= pin_cnt + FILT_W'(1);
      cause_q <= (cause_clr ? '0 : cause_q)
               | {src_req, ext_evt, por_evt};
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q <= ASSERT;
      sc_q    <= S_MAX;
      gc_q    <= '0;
      bc_q    <= '0;
      dom_q   <= '0;
      oe_q    <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      gc_q    <= gc_d;
      bc_q    <= bc_d;
      dom_q   <= dom_d;
      oe_q    <= oe_d;
      busy_q  <= (state_d != RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    gc_d    = gc_q;
    bc_d    = bc_q;
    dom_d   = dom_q;
    oe_d    = oe_q;
    unique case (state_q)
      ASSERT: begin
        dom_d = '0;
        oe_d  = 1'b1;
        if (trig) begin
          sc_d = S_MAX;
        end else if (sc_q == '0) begin
          state_d = RELEASE;
          gc_d    = G_MAX;
        end else begin
          sc_d = sc_q - SW'(1);
        end
      end
      RELEASE: begin
        if (trig) begin
          state_d = ASSERT;
          dom_d   = '0;
          oe_d    = 1'b1;
          sc_d    = S_MAX;
        end else if (gc_q != '0) begin
          gc_d = gc_q - GW'(1);
        end else if (!(&dom_q)) begin
          // Domains form a thermometer code: shift in the next one.
          dom_d = (dom_q << 1) | NCH'(1);
          gc_d  = G_MAX;
        end else begin
          state_d = RUN;
          oe_d    = 1'b0;
          bc_d    = B_MAX;
        end
      end
      RUN: begin
        if (trig) begin
          state_d = ASSERT;
          dom_d   = '0;
          oe_d    = 1'b1;
          sc_d    = S_MAX;
        end else if (bc_q != '0) begin
          bc_d = bc_q - BW'(1);
        end
      end
      default: begin
        state_d = ASSERT;
        dom_d   = '0;
        oe_d    = 1'b1;
        sc_d    = S_MAX;
      end
    endcase
  end

  assign cpu_rst_oe = oe_q;
  assign dom_rst_n  = dom_q;
  assign cause      = cause_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timing-level reference model feeding
// a scoreboard, checked every cycle by an independent monitor.
module tb_rst_sequencer;
  localparam int NCH     = 3;
  localparam int NSRC    = 2;
  localparam int FILT_W  = 3;
  localparam int STRETCH = 8;
  localparam int STAGGER = 4;
  localparam int BLANK   = 16;
  localparam int CW      = NSRC + 2;
  localparam int SAT     = (1 << FILT_W) - 1;

  logic clk28 = 1'b0;
  logic rst, por_n, cpu_rst_pin_n, cause_clr;
  logic [NSRC-1:0] src_req;
  logic cpu_rst_oe, busy;
  logic [NCH-1:0] dom_rst_n;
  logic [CW-1:0] cause;
  logic ext_low;

  typedef struct packed {
    logic [NCH-1:0] dom;
    logic oe;
    logic busy;
    logic [CW-1:0] cause;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  rst_sequencer #(
    .NCH(NCH), .NSRC(NSRC), .FILT_W(FILT_W),
    .STRETCH(STRETCH), .STAGGER(STAGGER), .BLANK(BLANK)
  ) dut (
    .clk28(clk28),
    .rst(rst),
    .por_n(por_n),
    .src_req(src_req),
    .cpu_rst_pin_n(cpu_rst_pin_n),
    .cpu_rst_oe(cpu_rst_oe),
    .dom_rst_n(dom_rst_n),
    .cause(cause),
    .cause_clr(cause_clr),
    .busy(busy)
  );

  always #5 clk28 = ~clk28;

  // Reference model: phases tracked by elapsed time, not counters.
  typedef enum int {M_ASSERT, M_REL, M_RUN} mode_t;
  mode_t mode;
  int quiet, rel_age, run_age, por_run, pin_run;
  logic por_s1, por_s2, pin_s1, pin_s2;
  logic [CW-1:0] m_cause;

  task automatic model_step();
    logic por_evt, ext_evt, trig, en;
    exp_t e;
    int n;
    if (rst) begin
      mode = M_ASSERT;
      quiet = 0; rel_age = 0; run_age = 0;
      por_run = 0; pin_run = 0;
      por_s1 = 1; por_s2 = 1; pin_s1 = 1; pin_s2 = 1;
      m_cause = CW'(1);
    end else begin
      por_evt = (por_run == SAT);
      ext_evt = (pin_run == SAT);
      trig = por_evt || ext_evt || (src_req != '0);
      en = (mode == M_RUN) && (run_age >= BLANK - 1);
      m_cause = (cause_clr ? '0 : m_cause) | {src_req, ext_evt, por_evt};
      por_run = !por_s2 ? ((por_run < SAT) ? por_run + 1 : SAT) : 0;
      pin_run = (en && !pin_s2) ? ((pin_run < SAT) ? pin_run + 1 : SAT) : 0;
      por_s2 = por_s1; por_s1 = por_n;
      pin_s2 = pin_s1; pin_s1 = cpu_rst_pin_n;
      if (trig) begin
        mode = M_ASSERT;
        quiet = 0;
      end else begin
        case (mode)
          M_ASSERT: begin
            quiet++;
            if (quiet == STRETCH) begin
              mode = M_REL;
              rel_age = 0;
            end
          end
          M_REL: begin
            rel_age++;
            if (rel_age == (NCH + 1) * STAGGER) begin
              mode = M_RUN;
              run_age = 0;
            end
          end
          default: if (run_age < BLANK) run_age++;
        endcase
      end
    end
    e.cause = m_cause;
    case (mode)
      M_ASSERT: begin
        e.dom = '0; e.oe = 1'b1; e.busy = 1'b1;
      end
      M_REL: begin
        n = rel_age / STAGGER;
        if (n > NCH) n = NCH;
        e.dom = NCH'((1 << n) - 1);
        e.oe = 1'b1; e.busy = 1'b1;
      end
      default: begin
        e.dom = '1; e.oe = 1'b0; e.busy = 1'b0;
      end
    endcase
    sb.push_back(e);
  endtask

  // One clock: resolve the open-drain line, predict, advance.
  task automatic apply();
    cpu_rst_pin_n = !((cpu_rst_oe === 1'b1) || ext_low);
    model_step();
    @(posedge clk28);
    #1;
    cyc++;
  endtask

  task automatic wait_run(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      apply();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_run cyc %0d: busy=%b required 0 within %0d", cyc, busy, lim);
    end
  endtask

  task automatic wait_dom(input logic [NCH-1:0] v, input int lim);
    int n = 0;
    while (dom_rst_n !== v && n < lim) begin
      apply();
      n++;
    end
    vectors++;
    if (dom_rst_n !== v) begin
      errors++;
      $display("FAIL wait_dom cyc %0d: dom=%b required %b", cyc, dom_rst_n, v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk28);
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard cyc %0d: no expectation queued", cyc);
      end else begin
        e = sb.pop_front();
        if ({dom_rst_n, cpu_rst_oe, busy, cause} !== e) begin
          errors++;
          $display("FAIL outputs cyc %0d: dom/oe/busy/cause got %b/%b/%b/%b required %b/%b/%b/%b",
                   cyc, dom_rst_n, cpu_rst_oe, busy, cause,
                   e.dom, e.oe, e.busy, e.cause);
        end
      end
    end
  end

  initial begin
    int por_left = 0;
    int pin_left = 0;
    int src_left = 0;
    logic [NSRC-1:0] src_hold = '0;
    rst = 1; por_n = 1; src_req = '0; ext_low = 0; cause_clr = 0;
    cpu_rst_pin_n = 1;
    repeat (3) apply();
    rst = 0;
    repeat (40) apply();
    src_req = 2'b10;
    repeat (20) apply();
    src_req = '0;
    repeat (50) apply();
    por_n = 0; repeat (6) apply(); por_n = 1;
    repeat (30) apply();
    por_n = 0; repeat (9) apply(); por_n = 1;
    repeat (50) apply();
    src_req = 2'b01; cause_clr = 1; apply();
    src_req = '0; cause_clr = 0;
    wait_run(100);
    repeat (20) apply();
    cause_clr = 1; apply(); cause_clr = 0;
    repeat (5) apply();
    src_req = 2'b01; apply(); src_req = '0;
    wait_run(100);
    repeat (2) apply();
    ext_low = 1; repeat (10) apply(); ext_low = 0;
    repeat (20) apply();
    ext_low = 1; repeat (7) apply(); ext_low = 0;
    repeat (10) apply();
    wait_dom(3'b011, 100);
    src_req = 2'b10; apply(); src_req = '0;
    repeat (60) apply();
    for (int i = 0; i < 3000; i++) begin
      if (por_left > 0) por_left--;
      else if ($urandom_range(0, 149) == 0) por_left = $urandom_range(1, 12);
      if (pin_left > 0) pin_left--;
      else if ($urandom_range(0, 59) == 0) pin_left = $urandom_range(1, 12);
      if (src_left > 0) src_left--;
      else if ($urandom_range(0, 79) == 0) begin
        src_left = $urandom_range(1, 10);
        src_hold = NSRC'($urandom_range(1, (1 << NSRC) - 1));
      end
      por_n = (por_left == 0);
      ext_low = (pin_left != 0);
      src_req = (src_left != 0) ? src_hold : '0;
      cause_clr = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 699) == 0);
      apply();
    end
    rst = 0; por_n = 1; ext_low = 0; src_req = '0; cause_clr = 0;
    repeat (40) apply();
    @(negedge clk28);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised reset controller for the ULA CPLD. It replaces the ad-hoc power-on, user-reset and CPU-reset-pin counters currently in the top level.
- It filters the raw board reset and the bidirectional Z80 reset line, and accepts NSRC user reset requests (PS/2 reset key, magic reboot, ...).
- It stretches each reset to a minimum width, then releases NCH reset domains one at a time in a fixed staggered order.
- It keeps a sticky reset-cause register that the magic ROM can read.

Parameters:
- NCH, 3, number of sequenced reset domains; domain 0 is released first.
- NSRC, 2, number of user reset request inputs.
- FILT_W, 3, filter counter width; an input must be stable low for 2^FILT_W-1 consecutive cycles to count.
- STRETCH, 8, minimum ASSERT duration in clk28 cycles (>=1).
- STAGGER, 4, cycles between successive domain releases (>=1).
- BLANK, 16, cycles after entering RUN during which cpu_rst_pin_n is ignored (allows a slow pull-up to recover).

Ports:
- clk28  in  1  system clock; the block uses this one clock only.
- rst  in  1  reset; synchronous, active-high.
- por_n  in  1  raw board reset pin, active-low, asynchronous.
- src_req  in  NSRC  user reset requests; level-sensitive, active-high.
- cpu_rst_pin_n  in  1  sampled level of the open-drain CPU reset line.
- cpu_rst_oe  out  1  1 = drive the CPU reset line low.
- dom_rst_n  out  NCH  per-domain resets, active-low.
- cause  out  NSRC+2  sticky cause bits: [0] board por, [1] external CPU pin, [2+i] src_req[i].
- cause_clr  in  1  single-cycle pulse; clears cause.
- busy  out  1  1 whenever state != RUN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values, while rst=1:
  - state=ASSERT; dom_rst_n=0; cpu_rst_oe=1; busy=1.
  - cause = 1 in bit 0, 0 in all other bits.
  - stretch counter = STRETCH-1; filters cleared.
  - rst asserted mid-sequence aborts any state immediately.
- por filter:
  - por_n passes through a 2-FF synchroniser, then a FILT_W-bit counter.
  - The counter increments while the synchronised level is 0, saturates at all-ones, and clears on 1.
  - por_evt = counter saturated.
  - Latency from a por_n fall to por_evt: 2 + 2^FILT_W-1 cycles.
- Pin filter:
  - Same structure as the por filter, applied to cpu_rst_pin_n.
  - Counter is held at 0 unless state=RUN and the blank counter is 0.
  - ext_evt = saturated.
  - Our own drive is never seen as an external reset.
- trig = por_evt | ext_evt | (|src_req).
- State ASSERT:
  - All dom_rst_n=0; cpu_rst_oe=1.
  - Stretch counter reloads STRETCH-1 on every cycle where trig=1, otherwise decrements.
  - When counter==0 and trig=0: go to RELEASE, load stagger counter STAGGER-1, idx=0.
- State RELEASE:
  - Stagger counter decrements each cycle.
  - At 0: if idx<NCH, set dom_rst_n[idx]=1, idx++, reload. If idx==NCH, set cpu_rst_oe=0, go to RUN, busy=0, blank counter=BLANK-1.
  - Domain k goes high (k+1)*STAGGER cycles after RELEASE entry.
  - cpu_rst_oe falls (NCH+1)*STAGGER cycles after RELEASE entry.
  - trig=1 in any RELEASE cycle: go to ASSERT next cycle, all domains reasserted, stretch counter reloaded.
- State RUN:
  - All dom_rst_n=1; blank counter counts down to 0.
  - trig=1: go to ASSERT; outputs assert on the next edge (1-cycle latency from trig).
- Domain order: a higher domain is never released while a lower one is still in reset. Any reassertion is simultaneous across all domains.
- cause update:
  - Each event bit is set in every cycle its event (por_evt, ext_evt, src_req[i]) is 1.
  - cause_clr clears all bits.
  - If set and clear occur in the same cycle, set wins for that bit.
  - cause is unaffected by state transitions other than rst.
- Counter widths: use clog2 of the respective parameter (minimum 1 bit); no wrap-around is permitted, only saturation or reload.

Test Plan:
- rst 1->0, inputs idle (NCH=3, STRETCH=8, STAGGER=4): ASSERT holds for 8 cycles; dom_rst_n goes 001, 011, 111 at +4, +8 and +12 after RELEASE entry; cpu_rst_oe=0 and busy=0 at +16; cause=0b0001.
- In RUN, src_req[1] high for 20 cycles: dom_rst_n=000 on the next edge; RELEASE starts 8 cycles after src_req falls; cause bit3=1.
- por_n glitch low for 6 cycles (FILT_W=3): no reset. Low for 7+2 cycles: ASSERT entered, cause[0]=1.
- cpu_rst_pin_n driven low externally during the BLANK window: ignored. Driven low for 7 cycles after BLANK expires: ASSERT entered, cause[1]=1. Our own cpu_rst_oe never sets cause[1].
- src_req pulse while domain 1 is released but domain 2 is not: all domains return to 0 the next cycle and the full sequence restarts.
- cause_clr issued in the same cycle as src_req[0]=1: cause[2] stays 1 and all other bits clear. cause_clr alone: cause=0.
